// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one registered-read RAM between two clients.
// Each access is latched in IDLE and sequenced ISSUE -> (READ) -> ACK.
module ram_arbiter #(
    parameter int AW = 3,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          clrn,
    input  logic          req0,
    input  logic          we0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    output logic          ack0,
    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    output logic          ack1,
    output logic [DW-1:0] rdata,
    output logic          rvalid,
    output logic          busy,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout
);

    typedef enum logic [1:0] {IDLE, ISSUE, READ, ACK} state_t;

    typedef struct packed {
        logic          cur;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } cmd_t;

    logic [1:0]         req_v;
    logic [1:0]         we_v;
    logic [1:0][AW-1:0] addr_v;
    logic [1:0][DW-1:0] wdata_v;

    state_t          state_q, state_d;
    cmd_t            cmd_q;
    logic            last_q;
    logic            gnt;
    logic            take;
    logic [DW-1:0]   rdata_q;

    assign req_v   = {req1, req0};
    assign we_v    = {we1, we0};
    assign addr_v  = {addr1, addr0};
    assign wdata_v = {wdata1, wdata0};

    // On a tie the client that was not served last wins.
    assign gnt = (req_v[0] & req_v[1]) ? ~last_q : req_v[1];

    always_comb begin
        state_d = state_q;
        take    = 1'b0;
        case (state_q)
            IDLE: begin
                if (|req_v) begin
                    take    = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE:   state_d = cmd_q.we ? ACK : READ;
            READ:    state_d = ACK;
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!clrn) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            cmd_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (take)
                cmd_q <= '{cur: gnt, we: we_v[gnt], addr: addr_v[gnt], wdata: wdata_v[gnt]};
            if (state_q == READ)
                rdata_q <= ram_dout;
            if (state_q == ACK)
                last_q <= cmd_q.cur;
        end
    end

    // Address/data come straight from the latched command, so they hold
    // their last values through IDLE; the write strobe is cut by reset.
    assign ram_addr = cmd_q.addr;
    assign ram_din  = cmd_q.wdata;
    assign ram_we   = (state_q == ISSUE) & cmd_q.we & clrn;

    assign ack0   = (state_q == ACK) & ~cmd_q.cur;
    assign ack1   = (state_q == ACK) &  cmd_q.cur;
    assign rvalid = (state_q == ACK) & ~cmd_q.we;
    assign busy   = (state_q != IDLE);
    assign rdata  = rdata_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: transaction table plus hand sequences for
// tie-break, fairness and reset during a write. Includes a registered-read RAM.
module tb_ram_arbiter;

    logic       clk = 1'b0;
    logic       clrn;
    logic       req0, we0, req1, we1;
    logic [2:0] addr0, addr1;
    logic [7:0] wdata0, wdata1;
    logic       ack0, ack1, rvalid, busy, ram_we;
    logic [7:0] rdata, ram_din, ram_dout;
    logic [2:0] ram_addr;
    logic       load;

    logic [7:0] mem [8];

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    ram_arbiter #(.AW(3), .DW(8)) dut (
        .clk(clk), .clrn(clrn),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1),
        .rdata(rdata), .rvalid(rvalid), .busy(busy),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
    );

    always @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < 8; i++) mem[i] <= 8'h10 + 8'(i);
        end else if (ram_we) begin
            mem[ram_addr] <= ram_din;
        end
        ram_dout <= mem[ram_addr];
    end

    typedef struct {
        logic       c;
        logic       we;
        logic [2:0] a;
        logic [7:0] d;
        int         lat;
        logic [7:0] exp_rd;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic set_client(input logic c, input logic r, input logic w,
                              input logic [2:0] a, input logic [7:0] d);
        if (c) begin req1 = r; we1 = w; addr1 = a; wdata1 = d; end
        else   begin req0 = r; we0 = w; addr0 = a; wdata0 = d; end
    endtask

    // Raises one request in an IDLE cycle and checks the whole access.
    task automatic access(input vec_t v, input string tag);
        int  n;
        logic got;
        @(negedge clk);
        set_client(v.c, 1'b1, v.we, v.a, v.d);
        n = 0;
        got = 1'b0;
        while (!got && n < 12) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                chk({tag, " ram_we"}, 32'(ram_we), 32'(v.we));
                chk({tag, " ram_addr"}, 32'(ram_addr), 32'(v.a));
                if (v.we) chk({tag, " ram_din"}, 32'(ram_din), 32'(v.d));
            end
            if (ack0 | ack1) got = 1'b1;
        end
        chk({tag, " acked"}, 32'(got), 32'd1);
        chk({tag, " latency"}, 32'(n), 32'(v.lat));
        chk({tag, " ack_own"}, 32'(v.c ? ack1 : ack0), 32'd1);
        chk({tag, " ack_other"}, 32'(v.c ? ack0 : ack1), 32'd0);
        chk({tag, " rvalid"}, 32'(rvalid), 32'(!v.we));
        chk({tag, " rdata"}, 32'(rdata), 32'(v.exp_rd));
        set_client(v.c, 1'b0, 1'b0, 3'd0, 8'd0);
    endtask

    initial begin
        int   n;
        int   k;
        logic order [6];

        clrn = 1'b0; load = 1'b1;
        req0 = 0; we0 = 0; addr0 = 0; wdata0 = 0;
        req1 = 0; we1 = 0; addr1 = 0; wdata1 = 0;

        //                  c  we  a   d      lat exp_rd
        tbl[0] = '{1'b0, 1'b1, 3'd3, 8'hA5, 2, 8'h17};
        tbl[1] = '{1'b0, 1'b0, 3'd3, 8'h00, 3, 8'hA5};
        tbl[2] = '{1'b1, 1'b1, 3'd5, 8'h5A, 2, 8'hA5};
        tbl[3] = '{1'b1, 1'b0, 3'd5, 8'h00, 3, 8'h5A};
        tbl[4] = '{1'b0, 1'b0, 3'd2, 8'h00, 3, 8'h12};
        tbl[5] = '{1'b1, 1'b1, 3'd7, 8'hFF, 2, 8'h12};
        tbl[6] = '{1'b0, 1'b1, 3'd0, 8'h00, 2, 8'h12};
        tbl[7] = '{1'b0, 1'b0, 3'd7, 8'h00, 3, 8'hFF};
        tbl[8] = '{1'b1, 1'b0, 3'd3, 8'h00, 3, 8'hA5};
        tbl[9] = '{1'b1, 1'b0, 3'd0, 8'h00, 3, 8'h00};

        // Reset held two cycles, then idle with no requests.
        repeat (2) @(negedge clk);
        load = 1'b0;
        chk("rst ack0", 32'(ack0), 0);
        chk("rst ack1", 32'(ack1), 0);
        chk("rst rvalid", 32'(rvalid), 0);
        chk("rst busy", 32'(busy), 0);
        chk("rst rdata", 32'(rdata), 0);
        chk("rst ram_we", 32'(ram_we), 0);
        clrn = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle busy", 32'(busy), 0);

        // Tie right after reset: client 0 first, client 1 four cycles later.
        req0 = 1; we0 = 0; addr0 = 3'd1;
        req1 = 1; we1 = 0; addr1 = 3'd2;
        n = 0; k = 0;
        while (k < 2 && n < 20) begin
            @(negedge clk);
            n++;
            if (ack0) begin
                chk("tie ack0 cycle", 32'(n), 3);
                chk("tie rdata0", 32'(rdata), 32'h11);
                req0 = 0; k++;
            end
            if (ack1) begin
                chk("tie ack1 cycle", 32'(n), 7);
                chk("tie rdata1", 32'(rdata), 32'h12);
                req1 = 0; k++;
            end
        end
        chk("tie both acked", 32'(k), 2);
        req0 = 0; req1 = 0;

        // Reset during ISSUE of a client-1 write: aborted, never acked.
        @(negedge clk);
        req1 = 1; we1 = 1; addr1 = 3'd7; wdata1 = 8'h3C;
        @(negedge clk);
        chk("abort in issue", 32'(ram_we), 1);
        clrn = 1'b0;
        req1 = 0;
        #1 chk("abort ram_we gated", 32'(ram_we), 0);
        @(negedge clk);
        chk("abort busy", 32'(busy), 0);
        clrn = 1'b1;
        k = 0;
        repeat (4) begin
            @(negedge clk);
            if (ack0 | ack1) k++;
        end
        chk("abort no ack", 32'(k), 0);
        access('{1'b1, 1'b0, 3'd7, 8'h00, 3, 8'h17}, "abort readback");

        foreach (tbl[i]) access(tbl[i], $sformatf("vec%0d", i));

        // Both requests held: grants must alternate starting with client 0.
        @(negedge clk);
        req0 = 1; we0 = 1; addr0 = 3'd4; wdata0 = 8'h44;
        req1 = 1; we1 = 1; addr1 = 3'd6; wdata1 = 8'h66;
        n = 0; k = 0;
        while (k < 6 && n < 40) begin
            @(negedge clk);
            n++;
            if (ack0 | ack1) begin
                order[k] = ack1;
                k++;
            end
        end
        req0 = 0; req1 = 0;
        chk("fair count", 32'(k), 6);
        for (int i = 0; i < 6; i++)
            chk($sformatf("fair order%0d", i), 32'(order[i]), 32'(i % 2));
        access('{1'b0, 1'b0, 3'd6, 8'h00, 3, 8'h66}, "fair readback");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
